// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment codes (bit7=a .. bit1=g, bit0=dp),
// decoder defaults and small helpers used on both the encode and decode side.
package seg7_pkg;

    localparam int unsigned STABLE_CYCLES_DEFAULT = 4;

    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hE6;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Clears the decimal point so it never takes part in a comparison.
    localparam logic [7:0] DP_MASK   = 8'hFE;

    localparam logic [9:0] VALUE_MAX = 10'd999;

    typedef enum logic {
        ST_SYNC,
        ST_LOCKED
    } seq_state_e;

    // A three-digit display pattern; 'none' marks "nothing accepted yet".
    typedef struct packed {
        logic       none;
        logic [7:0] d2;
        logic [7:0] d1;
        logic [7:0] d0;
    } seg_key_t;

    localparam seg_key_t KEY_NONE = '{none: 1'b1, d2: 8'h00, d1: 8'h00, d0: 8'h00};

    function automatic logic [9:0] bcd_to_bin(input logic [3:0] d2,
                                              input logic [3:0] d1,
                                              input logic [3:0] d0);
        return 10'(d2) * 10'd100 + 10'(d1) * 10'd10 + 10'(d0);
    endfunction

endpackage

// File: rtl/seg7_decoder_3_if.sv
// Display-side bundle of the three-digit decoder: raw segment inputs in,
// decoded digits, value, status pulses and error counters out.
interface seg7_decoder_3_if;

    logic [7:0] seg0;
    logic [7:0] seg1;
    logic [7:0] seg2;
    logic [3:0] bcd0;
    logic [3:0] bcd1;
    logic [3:0] bcd2;
    logic [9:0] value;
    logic       valid;
    logic       pattern_err;
    logic       seq_err;
    logic [7:0] pattern_err_cnt;
    logic [7:0] seq_err_cnt;
    logic       locked;

    modport master (
        output seg0, seg1, seg2,
        input  bcd0, bcd1, bcd2, value, valid, pattern_err, seq_err,
               pattern_err_cnt, seq_err_cnt, locked
    );

    modport slave (
        input  seg0, seg1, seg2,
        output bcd0, bcd1, bcd2, value, valid, pattern_err, seq_err,
               pattern_err_cnt, seq_err_cnt, locked
    );

endinterface

// File: rtl/seg7_digit_dec.sv
// Single-digit seven-segment to BCD decoder; dp is masked off before matching.
module seg7_digit_dec
    import seg7_pkg::*;
(
    input  logic [7:0] pat,
    output logic [3:0] bcd,
    output logic       digit_ok,
    output logic       blank
);

    logic [7:0] masked;

    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which is what would otherwise infer a latch.
    always_comb begin
        masked   = pat & DP_MASK;
        bcd      = 4'd0;
        digit_ok = 1'b1;
        blank    = (masked == SEG_BLANK);
        case (masked)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: digit_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_decoder_3.sv
// Three-digit display snooper: debounces the segment bus, decodes accepted
// patterns and checks that successive values count up by one modulo 1000.
module seg7_decoder_3
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    seg7_decoder_3_if.slave bus
);

    localparam logic [3:0] STABLE_LIM = 4'(STABLE_CYCLES);

    logic [7:0] seg0_q, seg1_q, seg2_q;
    seg_key_t   in_key;
    seg_key_t   cand_q, cand_d;
    seg_key_t   last_q, last_d;
    logic [3:0] stab_q, stab_d;
    seq_state_e state_q, state_d;

    logic [3:0] bcd0_q, bcd0_d, bcd1_q, bcd1_d, bcd2_q, bcd2_d;
    logic [9:0] value_q, value_d;
    logic       valid_q, valid_d;
    logic       pattern_err_q, pattern_err_d;
    logic       seq_err_q, seq_err_d;
    logic [7:0] pattern_err_cnt_q, pattern_err_cnt_d;
    logic [7:0] seq_err_cnt_q, seq_err_cnt_d;
    logic       locked_q, locked_d;

    logic [3:0] dig0, dig1, dig2;
    logic       ok0, ok1, ok2;
    logic       blank0, blank1, blank2;
    logic       accept;
    logic [9:0] new_value;
    logic [9:0] next_value;

    // NOTE: the input stage is a plain sampling register with no reset; its
    // contents are ignored until the candidate logic, which is reset, sees them.
    always_ff @(posedge clk) begin
        seg0_q <= bus.seg0;
        seg1_q <= bus.seg1;
        seg2_q <= bus.seg2;
    end

    assign in_key = '{none: 1'b0,
                      d2:   seg2_q & DP_MASK,
                      d1:   seg1_q & DP_MASK,
                      d0:   seg0_q & DP_MASK};

    seg7_digit_dec u_dig0 (.pat(cand_q.d0), .bcd(dig0), .digit_ok(ok0), .blank(blank0));
    seg7_digit_dec u_dig1 (.pat(cand_q.d1), .bcd(dig1), .digit_ok(ok1), .blank(blank1));
    seg7_digit_dec u_dig2 (.pat(cand_q.d2), .bcd(dig2), .digit_ok(ok2), .blank(blank2));

    always_comb begin
        cand_d            = in_key;
        last_d            = last_q;
        stab_d            = stab_q;
        state_d           = state_q;
        bcd0_d            = bcd0_q;
        bcd1_d            = bcd1_q;
        bcd2_d            = bcd2_q;
        value_d           = value_q;
        valid_d           = 1'b0;
        pattern_err_d     = 1'b0;
        seq_err_d         = 1'b0;
        pattern_err_cnt_d = pattern_err_cnt_q;
        seq_err_cnt_d     = seq_err_cnt_q;
        new_value         = bcd_to_bin(dig2, dig1, dig0);
        next_value        = (value_q == VALUE_MAX) ? 10'd0 : value_q + 10'd1;

        // The candidate register lags the input stage by one sample, so a
        // mismatch means the bus just changed and counting restarts.
        if (in_key != cand_q) begin
            stab_d = 4'd1;
        end else if (stab_q < STABLE_LIM) begin
            stab_d = stab_q + 4'd1;
        end

        accept = (in_key == cand_q) && (stab_q == STABLE_LIM) && (cand_q != last_q);

        if (accept) begin
            last_d = cand_q;
            if (blank0 && blank1 && blank2) begin
                state_d = ST_SYNC;
            end else if (ok0 && ok1 && ok2) begin
                valid_d = 1'b1;
                bcd0_d  = dig0;
                bcd1_d  = dig1;
                bcd2_d  = dig2;
                value_d = new_value;
                state_d = ST_LOCKED;
                if (state_q == ST_LOCKED && new_value != next_value) begin
                    seq_err_d = 1'b1;
                    if (seq_err_cnt_q != 8'hFF) begin
                        seq_err_cnt_d = seq_err_cnt_q + 8'd1;
                    end
                end
            end else begin
                // Bad pattern: reference value and FSM state stay untouched.
                pattern_err_d = 1'b1;
                if (pattern_err_cnt_q != 8'hFF) begin
                    pattern_err_cnt_d = pattern_err_cnt_q + 8'd1;
                end
            end
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q            <= KEY_NONE;
            last_q            <= KEY_NONE;
            stab_q            <= 4'd0;
            state_q           <= ST_SYNC;
            bcd0_q            <= 4'd0;
            bcd1_q            <= 4'd0;
            bcd2_q            <= 4'd0;
            value_q           <= 10'd0;
            valid_q           <= 1'b0;
            pattern_err_q     <= 1'b0;
            seq_err_q         <= 1'b0;
            pattern_err_cnt_q <= 8'd0;
            seq_err_cnt_q     <= 8'd0;
            locked_q          <= 1'b0;
        end else begin
            cand_q            <= cand_d;
            last_q            <= last_d;
            stab_q            <= stab_d;
            state_q           <= state_d;
            bcd0_q            <= bcd0_d;
            bcd1_q            <= bcd1_d;
            bcd2_q            <= bcd2_d;
            value_q           <= value_d;
            valid_q           <= valid_d;
            pattern_err_q     <= pattern_err_d;
            seq_err_q         <= seq_err_d;
            pattern_err_cnt_q <= pattern_err_cnt_d;
            seq_err_cnt_q     <= seq_err_cnt_d;
            locked_q          <= locked_d;
        end
    end

    assign bus.bcd0            = bcd0_q;
    assign bus.bcd1            = bcd1_q;
    assign bus.bcd2            = bcd2_q;
    assign bus.value           = value_q;
    assign bus.valid           = valid_q;
    assign bus.pattern_err     = pattern_err_q;
    assign bus.seq_err         = seq_err_q;
    assign bus.pattern_err_cnt = pattern_err_cnt_q;
    assign bus.seq_err_cnt     = seq_err_cnt_q;
    assign bus.locked          = locked_q;

endmodule

// File: doc/seg7_decoder_3.md
SEG7_DECODER_3 -- requirements
Module: seg7_decoder_3

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4 (range 1..15): consecutive identical samples required before a pattern is accepted.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have ports seg0/seg1/seg2, input, 8 each, segment patterns (bit7=a .. bit1=g, bit0=dp); seg0 = ones, seg1 = tens, seg2 = hundreds.
REQ-005 SHALL have ports bcd0/bcd1/bcd2, output, 4 each, last accepted decoded digits.
REQ-006 SHALL have port value, output, 10, last accepted value in binary, bcd2*100+bcd1*10+bcd0.
REQ-007 SHALL have port valid, output, 1, one-cycle pulse on each accepted valid pattern.
REQ-008 SHALL have ports pattern_err and seq_err, output, 1 each, one-cycle error pulses.
REQ-009 SHALL have ports pattern_err_cnt and seq_err_cnt, output, 8 each, saturating error counters.
REQ-010 SHALL have port locked, output, 1, high while the sequence checker is in LOCKED.

Function
REQ-011 SHALL register all three seg inputs in one input stage before any other logic.
REQ-012 SHALL ignore bit0 (dp) in all comparisons and decoding.
REQ-013 SHALL decode per digit: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1110011 (bits a..g); any other non-blank code is invalid.
REQ-014 SHALL treat a registered sample that differs from the previous one as a new candidate, clearing the stability counter.
REQ-015 SHALL accept a candidate once it has been held STABLE_CYCLES consecutive registered samples, and only if it differs from the last accepted pattern.
REQ-016 SHALL produce a 1-cycle pulse on valid, or on pattern_err, exactly STABLE_CYCLES+1 rising edges after the first edge that sampled the new pattern.
REQ-017 SHALL, on accepting an all-valid pattern: update bcd0..2 and value in the same cycle as the valid pulse.
REQ-018 SHALL, on accepting a pattern with any invalid digit: pulse pattern_err, increment pattern_err_cnt (saturate at 255), and leave bcd/value unchanged.
REQ-019 SHALL treat the all-blank pattern (all three digits a..g = 0) as neither valid nor error; acceptance returns the FSM to SYNC.
REQ-020 SHALL implement FSM SYNC/LOCKED: SYNC + valid -> LOCKED, no check; LOCKED + valid -> compare against previous value.
REQ-021 SHALL, in LOCKED, pulse seq_err and increment seq_err_cnt (saturate at 255) when new value != (prev+1) mod 1000, and remain LOCKED with the new value as reference.
REQ-022 SHALL treat 999 -> 000 as a correct step.
REQ-023 SHALL leave FSM state and reference value unchanged on a pattern_err.
REQ-024 SHALL never pulse more than one of valid and pattern_err in the same cycle.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, clear bcd0..2, value, valid, pattern_err, seq_err, both counters, and the stability counter; FSM -> SYNC; locked=0.
REQ-026 SHALL set the last-accepted pattern to an out-of-range marker on reset, so any stable pattern, including digit 000, is accepted after reset.
REQ-027 SHALL abort a stability count in progress when rst is asserted mid-operation, with no pulse produced.

Structure
REQ-028 SHALL place the SEG_0..SEG_9 and SEG_BLANK pattern constants and the STABLE_CYCLES default in shared package seg7_pkg, shared with the transmit-side encoder.
REQ-029 SHALL use one combinational sub-module seg7_digit_dec (8-bit pattern -> 4-bit BCD, digit_ok, blank), instantiated three times.

Verification
REQ-030 After reset, hold seg2/1/0 = 0x FC/FC/FC -> valid pulse 5 edges later; value=0; locked=1; no seq_err.
REQ-031 Step 000,001,...,009 with each held 6 cycles -> 10 valid pulses, value 0..9, seq_err_cnt=0; then 999 -> 000 -> no seq_err.
REQ-032 Jump 005 -> 007 -> one seq_err pulse; seq_err_cnt=1; then 008 -> no seq_err.
REQ-033 Drive seg0=0x02 (g only), held 6 cycles -> pattern_err pulse; pattern_err_cnt=1; value unchanged.
REQ-034 Toggle seg0 between 0x60 and 0xDA every 2 cycles -> no valid or pattern_err pulse; all-blank held 6 cycles -> locked=0, no error pulse.
REQ-035 Assert rst at stability count 2 -> no pulse; all outputs 0; the same pattern held afterwards is accepted 5 edges after rst deasserts.
